// File: rtl/cim_seq_ctrl.sv
// Upstream sequencer for the CIM macro: streams a full weight image into the macro write
// port, issues compute ops from an activation stream and queues macro results in a 2-entry FIFO.
module cim_seq_ctrl #(
  parameter int CORE_NUM         = 16,
  parameter int XIN_BIT_WIDTH    = 11,
  parameter int MEM_BIT_WIDTH    = 8,
  parameter int MEM_ADR_WIDTH    = 2,
  parameter int OUTPUT_BIT_WIDTH = 23,
  parameter int CIM_LAT          = 1
) (
  input  logic                                CLK,
  input  logic                                NRST,
  input  logic                                LOAD_START,
  input  logic                                W_VALID,
  output logic                                W_READY,
  input  logic [MEM_BIT_WIDTH-1:0]            W_DATA,
  input  logic                                X_VALID,
  output logic                                X_READY,
  input  logic [CORE_NUM*XIN_BIT_WIDTH-1:0]   X_DATA,
  input  logic [MEM_ADR_WIDTH-1:0]            X_ADR,
  output logic                                Y_VALID,
  input  logic                                Y_READY,
  output logic [OUTPUT_BIT_WIDTH-1:0]         Y_DATA,
  output logic                                LOADED,
  output logic                                ENCB,
  output logic                                WEB,
  output logic                                REB,
  output logic [$clog2(CORE_NUM)-1:0]         BANKA,
  output logic [$clog2(CORE_NUM)-1:0]         BANKB,
  output logic [MEM_ADR_WIDTH-1:0]            ADRA,
  output logic [MEM_ADR_WIDTH-1:0]            ADRB,
  output logic [MEM_BIT_WIDTH-1:0]            D,
  output logic [CORE_NUM*XIN_BIT_WIDTH-1:0]   XIN,
  input  logic [OUTPUT_BIT_WIDTH-1:0]         Q,
  output logic [1:0]                          dbg_state
);

  // Handshakes: a transfer happens on the rising CLK edge where valid and ready are both
  // high; valid must hold with stable data until then, and ready never depends on valid.

  localparam int BANK_W = $clog2(CORE_NUM);
  localparam int CNT_W  = BANK_W + MEM_ADR_WIDTH;
  localparam int XW     = CORE_NUM * XIN_BIT_WIDTH;
  localparam int CRW    = $clog2(CIM_LAT + 4);
  localparam logic [CNT_W-1:0] LAST_WORD = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [CNT_W-1:0]            wcnt_q;
  logic                        fin_q;
  logic                        loaded_q;
  logic                        pending_q;
  logic [CIM_LAT:0]            pipe_q;
  logic [CRW-1:0]              inflight;
  logic [CRW-1:0]              credits;
  logic                        drained;
  logic                        w_hs;
  logic                        x_hs;
  logic                        start_load;

  logic                        web_q;
  logic                        encb_q;
  logic                        reb_q;
  logic [BANK_W-1:0]           banka_q;
  logic [BANK_W-1:0]           bankb_q;
  logic [MEM_ADR_WIDTH-1:0]    adra_q;
  logic [MEM_ADR_WIDTH-1:0]    adrb_q;
  logic [MEM_BIT_WIDTH-1:0]    d_q;
  logic [XW-1:0]               xin_q;

  logic [OUTPUT_BIT_WIDTH-1:0] mem_q [2];
  logic                        wr_ptr_q;
  logic                        rd_ptr_q;
  logic [1:0]                  fifo_cnt_q;
  logic                        push;
  logic                        pop;

  // Credits cover both ops still inside the macro and results waiting in the FIFO,
  // so an issued op always has a FIFO slot when its result arrives.
  always_comb begin
    inflight = '0;
    for (int i = 0; i <= CIM_LAT; i++) begin
      inflight = inflight + CRW'(pipe_q[i]);
    end
  end

  assign credits = inflight + CRW'(fifo_cnt_q);
  assign drained = (pipe_q == '0) && (fifo_cnt_q == 2'd0);

  assign W_READY = (state_q == S_LOAD);
  assign X_READY = (state_q == S_RUN) && !pending_q && (credits < CRW'(2));
  assign w_hs    = W_VALID && W_READY;
  assign x_hs    = X_VALID && X_READY;
  assign push    = pipe_q[CIM_LAT];
  assign pop     = (fifo_cnt_q != 2'd0) && Y_READY;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (LOAD_START) state_d = S_LOAD;
      S_LOAD: if (w_hs && (wcnt_q == LAST_WORD)) state_d = S_RUN;
      S_RUN:  if ((LOAD_START || pending_q) && drained) state_d = S_LOAD;
      default: state_d = S_IDLE;
    endcase
  end

  assign start_load = (state_q != S_LOAD) && (state_d == S_LOAD);

  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      state_q   <= S_IDLE;
      wcnt_q    <= '0;
      fin_q     <= 1'b0;
      loaded_q  <= 1'b0;
      pending_q <= 1'b0;
      pipe_q    <= '0;
    end else begin
      state_q <= state_d;
      pipe_q  <= {pipe_q[CIM_LAT-1:0], x_hs};
      fin_q   <= w_hs && (wcnt_q == LAST_WORD);
      if (start_load) begin
        wcnt_q    <= '0;
        loaded_q  <= 1'b0;
        pending_q <= 1'b0;
      end else begin
        if (w_hs) wcnt_q <= wcnt_q + 1'b1;
        // LOADED rises the cycle after the final write has been on the pins.
        if (fin_q) loaded_q <= 1'b1;
        if ((state_q == S_RUN) && LOAD_START && !drained) pending_q <= 1'b1;
      end
    end
  end

  // Macro pin registers: strobes are active low for exactly one cycle per handshake.
  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      web_q   <= 1'b1;
      encb_q  <= 1'b1;
      reb_q   <= 1'b1;
      banka_q <= '0;
      bankb_q <= '0;
      adra_q  <= '0;
      adrb_q  <= '0;
      d_q     <= '0;
      xin_q   <= '0;
    end else begin
      web_q   <= !w_hs;
      encb_q  <= !x_hs;
      reb_q   <= 1'b1;
      bankb_q <= '0;
      if (w_hs) begin
        d_q     <= W_DATA;
        banka_q <= wcnt_q[BANK_W-1:0];
        adra_q  <= wcnt_q[CNT_W-1:BANK_W];
      end
      if (x_hs) begin
        xin_q  <= X_DATA;
        adrb_q <= X_ADR;
      end
    end
  end

  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      mem_q[0]   <= '0;
      mem_q[1]   <= '0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      fifo_cnt_q <= 2'd0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= Q;
        wr_ptr_q        <= !wr_ptr_q;
      end
      if (pop) rd_ptr_q <= !rd_ptr_q;
      case ({push, pop})
        2'b10:   fifo_cnt_q <= fifo_cnt_q + 2'd1;
        2'b01:   fifo_cnt_q <= fifo_cnt_q - 2'd1;
        default: fifo_cnt_q <= fifo_cnt_q;
      endcase
    end
  end

  assign Y_VALID   = (fifo_cnt_q != 2'd0);
  assign Y_DATA    = mem_q[rd_ptr_q];
  assign LOADED    = loaded_q;
  assign WEB       = web_q;
  assign ENCB      = encb_q;
  assign REB       = reb_q;
  assign BANKA     = banka_q;
  assign BANKB     = bankb_q;
  assign ADRA      = adra_q;
  assign ADRB      = adrb_q;
  assign D         = d_q;
  assign XIN       = xin_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_cim_seq_ctrl.sv
// Directed bench for cim_seq_ctrl with a behavioural CIM macro attached to its pins.
`timescale 1ns/1ps
module tb_cim_seq_ctrl;

  localparam int CN = 16;
  localparam int XB = 11;
  localparam int MB = 8;
  localparam int AB = 2;
  localparam int OB = 23;
  localparam int XW = CN * XB;

  logic          CLK, NRST, LOAD_START, W_VALID, W_READY, X_VALID, X_READY;
  logic [MB-1:0] W_DATA;
  logic [XW-1:0] X_DATA;
  logic [AB-1:0] X_ADR;
  logic          Y_VALID, Y_READY, LOADED, ENCB, WEB, REB;
  logic [OB-1:0] Y_DATA;
  logic [3:0]    BANKA, BANKB;
  logic [AB-1:0] ADRA, ADRB;
  logic [MB-1:0] D;
  logic [XW-1:0] XIN;
  logic [OB-1:0] Q;
  logic [1:0]    dbg_state;

  int total = 0;
  int bad   = 0;
  logic [OB-1:0] exp_q[$];

  cim_seq_ctrl dut (
    .CLK(CLK), .NRST(NRST), .LOAD_START(LOAD_START),
    .W_VALID(W_VALID), .W_READY(W_READY), .W_DATA(W_DATA),
    .X_VALID(X_VALID), .X_READY(X_READY), .X_DATA(X_DATA), .X_ADR(X_ADR),
    .Y_VALID(Y_VALID), .Y_READY(Y_READY), .Y_DATA(Y_DATA), .LOADED(LOADED),
    .ENCB(ENCB), .WEB(WEB), .REB(REB), .BANKA(BANKA), .BANKB(BANKB),
    .ADRA(ADRA), .ADRB(ADRB), .D(D), .XIN(XIN), .Q(Q), .dbg_state(dbg_state)
  );

  // clock/reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  // behavioural macro: one write port, Q one cycle after an ENCB-low cycle
  logic [MB-1:0] wmem [CN][4];
  initial begin
    Q = '0;
    for (int k = 0; k < CN; k++)
      for (int r = 0; r < 4; r++) wmem[k][r] = '0;
  end

  function automatic logic [OB-1:0] mac(input logic [AB-1:0] adr, input logic [XW-1:0] x);
    logic [OB-1:0] s;
    s = '0;
    for (int k = 0; k < CN; k++) s = s + OB'(wmem[k][adr]) * OB'(x[k*XB +: XB]);
    return s;
  endfunction

  always @(posedge CLK) begin
    if (!WEB) wmem[BANKA][ADRA] <= D;
    if (!ENCB) Q <= mac(ADRB, XIN);
  end

  function automatic logic [XW-1:0] splat(input logic [XB-1:0] v);
    logic [XW-1:0] r;
    r = '0;
    for (int k = 0; k < CN; k++) r[k*XB +: XB] = v;
    return r;
  endfunction

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset;
    NRST = 1'b0; LOAD_START = 0; W_VALID = 0; W_DATA = '0; X_VALID = 0;
    X_DATA = '0; X_ADR = '0; Y_READY = 0;
    tick(); tick();
    total++; if ({WEB, ENCB, REB} !== 3'b111) begin bad++; $display("FAIL rst_strobes: got %b want 111", {WEB, ENCB, REB}); end
    total++; if ({BANKA, ADRA, D, BANKB, ADRB} !== '0) begin bad++; $display("FAIL rst_addr: got %h want 0", {BANKA, ADRA, D, BANKB, ADRB}); end
    total++; if (XIN !== '0) begin bad++; $display("FAIL rst_xin: got %h want 0", XIN); end
    total++; if ({W_READY, X_READY, Y_VALID, LOADED} !== 4'b0) begin bad++; $display("FAIL rst_flags: got %b want 0000", {W_READY, X_READY, Y_VALID, LOADED}); end
    total++; if (Y_DATA !== '0) begin bad++; $display("FAIL rst_ydata: got %h want 0", Y_DATA); end
    total++; if (dbg_state !== 2'd0) begin bad++; $display("FAIL rst_state: got %0d want 0", dbg_state); end
    NRST = 1'b1;
    tick();
    W_VALID = 1'b1; W_DATA = 8'hAA;
    tick();
    total++; if ({WEB, W_READY} !== 2'b10) begin bad++; $display("FAIL idle_no_write: got %b want 10", {WEB, W_READY}); end
    W_VALID = 1'b0;
  endtask

  task automatic start_load;
    LOAD_START = 1'b1;
    tick();
    LOAD_START = 1'b0;
    total++; if (dbg_state !== 2'd1) begin bad++; $display("FAIL start_load_state: got %0d want 1", dbg_state); end
  endtask

  // Streams 64 words back-to-back; row r of every bank gets value rv[r].
  task automatic load_words(input logic [7:0] r0, input logic [7:0] r1,
                            input logic [7:0] r2, input logic [7:0] r3);
    logic [7:0] rv[4];
    rv[0] = r0; rv[1] = r1; rv[2] = r2; rv[3] = r3;
    total++; if ({W_READY, LOADED} !== 2'b10) begin bad++; $display("FAIL load_entry: got %b want 10", {W_READY, LOADED}); end
    W_VALID = 1'b1; W_DATA = rv[0];
    for (int i = 0; i < 64; i++) begin
      LOAD_START = (i == 20);
      tick();
      total++;
      if ({WEB, BANKA, ADRA, D, LOADED} !== {1'b0, 4'(i % 16), 2'(i / 16), rv[i/16], 1'b0}) begin
        bad++;
        $display("FAIL load_word%0d: got web=%b bank=%0d adr=%0d d=%h ld=%b want web=0 bank=%0d adr=%0d d=%h ld=0",
                 i, WEB, BANKA, ADRA, D, LOADED, i % 16, i / 16, rv[i/16]);
      end
      if (i < 63) W_DATA = rv[(i+1)/16];
      else W_VALID = 1'b0;
    end
    LOAD_START = 1'b0;
    total++; if (W_READY !== 1'b0) begin bad++; $display("FAIL load_ready_drop: got %b want 0", W_READY); end
    tick();
    total++; if ({WEB, LOADED, dbg_state} !== {1'b1, 1'b1, 2'd2}) begin bad++; $display("FAIL load_done: got %b want 1110", {WEB, LOADED, dbg_state}); end
  endtask

  task automatic run_one(input logic [XB-1:0] xv, input logic [AB-1:0] adr, input logic [OB-1:0] exp);
    X_VALID = 1'b1; X_DATA = splat(xv); X_ADR = adr;
    total++; if (X_READY !== 1'b1) begin bad++; $display("FAIL run_ready: got %b want 1", X_READY); end
    tick();
    X_VALID = 1'b0;
    total++; if ({ENCB, REB, ADRB, BANKB} !== {1'b0, 1'b1, adr, 4'd0}) begin bad++; $display("FAIL run_pins: got %b want %b", {ENCB, REB, ADRB, BANKB}, {1'b0, 1'b1, adr, 4'd0}); end
    total++; if (XIN !== splat(xv)) begin bad++; $display("FAIL run_xin: got %h want %h", XIN, splat(xv)); end
    tick();
    total++; if ({ENCB, Y_VALID} !== 2'b10) begin bad++; $display("FAIL run_lat: got %b want 10", {ENCB, Y_VALID}); end
    tick();
    total++; if (Y_VALID !== 1'b1) begin bad++; $display("FAIL run_yvalid: got %b want 1", Y_VALID); end
    total++; if (Y_DATA !== exp) begin bad++; $display("FAIL run_ydata: got %h want %h", Y_DATA, exp); end
    Y_READY = 1'b1;
    tick();
    Y_READY = 1'b0;
    total++; if (Y_VALID !== 1'b0) begin bad++; $display("FAIL run_pop: got %b want 0", Y_VALID); end
    total++; if (XIN !== splat(xv)) begin bad++; $display("FAIL run_xin_hold: got %h want %h", XIN, splat(xv)); end
  endtask

  task automatic test_basic;
    start_load();
    load_words(8'h01, 8'h01, 8'h01, 8'h01);
    run_one(11'd5, 2'd0, 23'h000050);
    run_one(11'd5, 2'd3, 23'h000050);
  endtask

  task automatic test_max;
    start_load();
    load_words(8'hFF, 8'hFF, 8'hFF, 8'hFF);
    run_one(11'h7FF, 2'd0, 23'h7F7010);
    run_one(11'h7FF, 2'd2, 23'h7F7010);
  endtask

  // Issues x=1 then x=2 with Y_READY low, leaving both results in the FIFO.
  task automatic fill_fifo;
    Y_READY = 1'b0; X_VALID = 1'b1; X_DATA = splat(11'd1); X_ADR = 2'd1;
    total++; if (X_READY !== 1'b1) begin bad++; $display("FAIL fill_ready0: got %b want 1", X_READY); end
    tick();
    X_DATA = splat(11'd2);
    total++; if (X_READY !== 1'b1) begin bad++; $display("FAIL fill_ready1: got %b want 1", X_READY); end
    tick();
    X_DATA = splat(11'd3);
    total++; if (X_READY !== 1'b0) begin bad++; $display("FAIL fill_credit_stop: got %b want 0", X_READY); end
    tick();
    total++; if ({Y_VALID, Y_DATA} !== {1'b1, 23'h000FF0}) begin bad++; $display("FAIL fill_first: got %b/%h want 1/000ff0", Y_VALID, Y_DATA); end
  endtask

  task automatic test_back_to_back;
    int n_got;
    logic x_will_hs;
    logic [OB-1:0] want;
    fill_fifo();
    for (int c = 0; c < 3; c++) begin
      tick();
      total++; if ({Y_DATA, X_READY, ENCB} !== {23'h000FF0, 1'b0, 1'b1}) begin bad++; $display("FAIL b2b_hold%0d: got %h/%b/%b want 000ff0/0/1", c, Y_DATA, X_READY, ENCB); end
    end
    exp_q.push_back(23'h000FF0);
    exp_q.push_back(23'h001FE0);
    exp_q.push_back(23'h002FD0);
    Y_READY = 1'b1;
    n_got = 0;
    for (int c = 0; c < 20 && n_got < 3; c++) begin
      x_will_hs = X_VALID && X_READY;
      if (Y_VALID && Y_READY) begin
        want = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
        total++; if (Y_DATA !== want) begin bad++; $display("FAIL b2b_result%0d: got %h want %h", n_got, Y_DATA, want); end
        n_got++;
      end
      tick();
      if (x_will_hs) X_VALID = 1'b0;
    end
    Y_READY = 1'b0; X_VALID = 1'b0;
    total++; if (n_got !== 3) begin bad++; $display("FAIL b2b_count: got %0d want 3", n_got); end
    exp_q.delete();
  endtask

  task automatic test_load_pending;
    fill_fifo();
    X_VALID = 1'b0;
    tick();
    LOAD_START = 1'b1;
    tick();
    LOAD_START = 1'b0;
    X_VALID = 1'b1;
    total++; if ({X_READY, W_READY, dbg_state} !== {1'b0, 1'b0, 2'd2}) begin bad++; $display("FAIL pend_entry: got %b want 0010", {X_READY, W_READY, dbg_state}); end
    for (int c = 0; c < 3; c++) begin
      tick();
      total++; if ({WEB, W_READY, X_READY, ENCB} !== 4'b1001) begin bad++; $display("FAIL pend_hold%0d: got %b want 1001", c, {WEB, W_READY, X_READY, ENCB}); end
    end
    total++; if (Y_DATA !== 23'h000FF0) begin bad++; $display("FAIL pend_head0: got %h want 000ff0", Y_DATA); end
    Y_READY = 1'b1;
    tick();
    total++; if ({Y_DATA, W_READY} !== {23'h001FE0, 1'b0}) begin bad++; $display("FAIL pend_head1: got %h/%b want 001fe0/0", Y_DATA, W_READY); end
    tick();
    total++; if ({Y_VALID, W_READY, X_READY, dbg_state} !== {3'b000, 2'd2}) begin bad++; $display("FAIL pend_drained: got %b want 00010", {Y_VALID, W_READY, X_READY, dbg_state}); end
    tick();
    Y_READY = 1'b0; X_VALID = 1'b0;
    total++; if ({W_READY, ENCB, dbg_state} !== {2'b11, 2'd1}) begin bad++; $display("FAIL pend_reload: got %b want 1101", {W_READY, ENCB, dbg_state}); end
  endtask

  task automatic test_rows;
    load_words(8'd1, 8'd2, 8'd3, 8'd4);
    for (int r = 0; r < 4; r++) run_one(11'd1, 2'(r), 23'(16 * (r + 1)));
  endtask

  task automatic test_reset_mid;
    X_VALID = 1'b1; X_DATA = splat(11'd9); X_ADR = 2'd2;
    tick();
    X_VALID = 1'b0;
    total++; if (ENCB !== 1'b0) begin bad++; $display("FAIL mid_issue: got %b want 0", ENCB); end
    #1 NRST = 1'b0;
    #1;
    total++; if ({ENCB, LOADED, X_READY, Y_VALID, dbg_state} !== {4'b1000, 2'd0}) begin bad++; $display("FAIL mid_run_rst: got %b want 100000", {ENCB, LOADED, X_READY, Y_VALID, dbg_state}); end
    total++; if ({XIN, ADRB} !== '0) begin bad++; $display("FAIL mid_run_pins: got %h want 0", {XIN, ADRB}); end
    tick();
    NRST = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      total++; if (Y_VALID !== 1'b0) begin bad++; $display("FAIL mid_pipe_clr%0d: got %b want 0", c, Y_VALID); end
    end
    start_load();
    W_VALID = 1'b1; W_DATA = 8'h3C;
    repeat (10) tick();
    total++; if ({WEB, D} !== {1'b0, 8'h3C}) begin bad++; $display("FAIL mid_load_wr: got %b/%h want 0/3c", WEB, D); end
    #1 NRST = 1'b0;
    #1;
    total++; if ({WEB, W_READY, LOADED, dbg_state} !== {3'b100, 2'd0}) begin bad++; $display("FAIL mid_load_rst: got %b want 10000", {WEB, W_READY, LOADED, dbg_state}); end
    total++; if ({D, BANKA, ADRA} !== '0) begin bad++; $display("FAIL mid_load_pins: got %h want 0", {D, BANKA, ADRA}); end
    W_VALID = 1'b0;
    tick();
    NRST = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_max();
    test_back_to_back();
    test_load_pending();
    test_rows();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
